// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer: FSM state encoding and default timing.
package debounce_pkg;

    localparam logic [1:0] IDLE_LOW  = 2'b00;
    localparam logic [1:0] WAIT_HIGH = 2'b01;
    localparam logic [1:0] IDLE_HIGH = 2'b10;
    localparam logic [1:0] WAIT_LOW  = 2'b11;

    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        StIdleLow  = IDLE_LOW,
        StWaitHigh = WAIT_HIGH,
        StIdleHigh = IDLE_HIGH,
        StWaitLow  = WAIT_LOW
    } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous input into the clock domain.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/push_button_debouncer.sv
// Synchronizes and debounces a raw push-button; emits a clean level plus one-cycle
// press/release strobes, all registered.
module push_button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic input_clock1_clk_1,
    input  logic input_push_button2_rst_2,
    input  logic input_push_button3_btn_3,
    output logic output_led1_level_4,
    output logic output_led2_press_5,
    output logic output_led3_release_6
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_sync;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk  (input_clock1_clk_1),
        .rst  (input_push_button2_rst_2),
        .din  (input_push_button3_btn_3),
        .dout (btn_sync)
    );

    always_ff @(posedge input_clock1_clk_1 or posedge input_push_button2_rst_2) begin
        if (input_push_button2_rst_2) begin
            state_q   <= StIdleLow;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Entering a WAIT state counts the first agreeing sample, so acceptance happens on
    // the DEBOUNCE_CYCLES-th consecutive sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StIdleLow: begin
                level_d = 1'b0;
                if (btn_sync) begin
                    state_d = StWaitHigh;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitHigh: begin
                if (!btn_sync) begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdleHigh;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StIdleHigh: begin
                level_d = 1'b1;
                if (!btn_sync) begin
                    state_d = StWaitLow;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitLow: begin
                if (btn_sync) begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = StIdleLow;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = StIdleLow;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign output_led1_level_4   = level_q;
    assign output_led2_press_5   = press_q;
    assign output_led3_release_6 = release_q;

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed self-checking bench for push_button_debouncer at default parameters.
module tb_push_button_debouncer;

    logic clk;
    logic rst;
    logic btn;
    logic level;
    logic press;
    logic release_s;

    int checks;
    int errors;
    int press_cnt;
    int release_cnt;

    push_button_debouncer u_dut (
        .input_clock1_clk_1       (clk),
        .input_push_button2_rst_2 (rst),
        .input_push_button3_btn_3 (btn),
        .output_led1_level_4      (level),
        .output_led2_press_5      (press),
        .output_led3_release_6    (release_s)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Strobe counters plus mutual-exclusion check, sampled mid-cycle.
    always @(negedge clk) begin
        if (press) press_cnt++;
        if (release_s) release_cnt++;
        checks++;
        if (press && release_s) begin
            errors++;
            $display("FAIL strobe_exclusive: press=%0b release=%0b required not both 1",
                     press, release_s);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 1'b1;
        tick(3);
        checks += 3;
        if (level !== 1'b0) begin
            errors++; $display("FAIL reset_level: got %0b want 0", level);
        end
        if (press !== 1'b0) begin
            errors++; $display("FAIL reset_press: got %0b want 0", press);
        end
        if (release_s !== 1'b0) begin
            errors++; $display("FAIL reset_release: got %0b want 0", release_s);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (level !== 1'b0) begin
            errors++; $display("FAIL reset_held_edge5: level got %0b want 0", level);
        end
        tick(1);
        checks += 2;
        if (level !== 1'b1) begin
            errors++; $display("FAIL reset_held_edge6_level: got %0b want 1", level);
        end
        if (press !== 1'b1) begin
            errors++; $display("FAIL reset_held_edge6_press: got %0b want 1", press);
        end
        tick(1);
        checks++;
        if (press !== 1'b0) begin
            errors++; $display("FAIL reset_held_edge7_press: got %0b want 0", press);
        end
    endtask

    task automatic test_clean_release();
        int p0;
        int r0;
        p0 = press_cnt;
        r0 = release_cnt;
        btn = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            checks++;
            if (level !== 1'b1 || release_s !== 1'b0) begin
                errors++;
                $display("FAIL release_edge%0d: level=%0b release=%0b want level=1 release=0",
                         e, level, release_s);
            end
        end
        tick(1);
        checks++;
        if (level !== 1'b0 || release_s !== 1'b1) begin
            errors++;
            $display("FAIL release_edge6: level=%0b release=%0b want level=0 release=1",
                     level, release_s);
        end
        tick(1);
        checks += 2;
        if (release_s !== 1'b0) begin
            errors++; $display("FAIL release_edge7: release got %0b want 0", release_s);
        end
        if (press_cnt != p0 || release_cnt != r0 + 1) begin
            errors++;
            $display("FAIL release_counts: press=%0d release=%0d want press=%0d release=%0d",
                     press_cnt - p0, release_cnt - r0, 0, 1);
        end
    endtask

    task automatic test_clean_press();
        int p0;
        int r0;
        p0 = press_cnt;
        r0 = release_cnt;
        tick(3);
        btn = 1'b1;
        tick(5);
        checks++;
        if (level !== 1'b0 || press !== 1'b0) begin
            errors++;
            $display("FAIL press_edge5: level=%0b press=%0b want 0 0", level, press);
        end
        tick(1);
        checks++;
        if (level !== 1'b1 || press !== 1'b1 || release_s !== 1'b0) begin
            errors++;
            $display("FAIL press_edge6: level=%0b press=%0b release=%0b want 1 1 0",
                     level, press, release_s);
        end
        tick(1);
        checks += 2;
        if (press !== 1'b0 || level !== 1'b1) begin
            errors++;
            $display("FAIL press_edge7: level=%0b press=%0b want 1 0", level, press);
        end
        if (press_cnt != p0 + 1 || release_cnt != r0) begin
            errors++;
            $display("FAIL press_counts: press=%0d release=%0d want press=1 release=0",
                     press_cnt - p0, release_cnt - r0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        int r0;
        p0 = press_cnt;
        r0 = release_cnt;
        for (int k = 0; k < 4; k++) begin
            btn = ~k[0];
            tick(2);
        end
        btn = 1'b1;
        tick(5);
        checks += 2;
        if (level !== 1'b0) begin
            errors++; $display("FAIL bounce_level_before: got %0b want 0", level);
        end
        if (press_cnt != p0 || release_cnt != r0) begin
            errors++;
            $display("FAIL bounce_no_strobe: press=%0d release=%0d want 0 0",
                     press_cnt - p0, release_cnt - r0);
        end
        tick(1);
        checks++;
        if (level !== 1'b1 || press !== 1'b1) begin
            errors++;
            $display("FAIL bounce_edge6: level=%0b press=%0b want 1 1", level, press);
        end
        tick(1);
        checks++;
        if (press_cnt != p0 + 1) begin
            errors++; $display("FAIL bounce_single_press: got %0d want 1", press_cnt - p0);
        end
    endtask

    task automatic test_glitch_reject();
        int p0;
        int r0;
        p0 = press_cnt;
        r0 = release_cnt;
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(10);
        checks += 2;
        if (level !== 1'b0) begin
            errors++; $display("FAIL glitch_level: got %0b want 0", level);
        end
        if (press_cnt != p0 || release_cnt != r0) begin
            errors++;
            $display("FAIL glitch_no_strobe: press=%0d release=%0d want 0 0",
                     press_cnt - p0, release_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int p0;
        p0 = press_cnt;
        btn = 1'b1;
        // Four edges in, the FSM sits in WAIT_HIGH with the count part-way up.
        tick(4);
        rst = 1'b1;
        btn = 1'b0;
        #1;
        checks++;
        if (level !== 1'b0 || press !== 1'b0) begin
            errors++;
            $display("FAIL midwait_in_reset: level=%0b press=%0b want 0 0", level, press);
        end
        tick(2);
        rst = 1'b0;
        tick(8);
        checks++;
        if (press_cnt != p0 || level !== 1'b0) begin
            errors++;
            $display("FAIL midwait_aborted: presses=%0d level=%0b want 0 0",
                     press_cnt - p0, level);
        end
        btn = 1'b1;
        tick(5);
        checks++;
        if (level !== 1'b0) begin
            errors++; $display("FAIL midwait_repress_edge5: level got %0b want 0", level);
        end
        tick(1);
        checks++;
        if (level !== 1'b1 || press !== 1'b1) begin
            errors++;
            $display("FAIL midwait_repress_edge6: level=%0b press=%0b want 1 1", level, press);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        press_cnt   = 0;
        release_cnt = 0;
        rst         = 1'b1;
        btn         = 1'b0;
        #1;
        test_reset();
        test_clean_release();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_clean_release();
        test_glitch_reject();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
